// File: rtl/ntt_pkg.sv
// Shared constants and types for the ML-KEM NTT control path.
package ntt_pkg;
    localparam int N      = 256;
    localparam int LOG_N  = 8;
    localparam int NLAYER = 7;
    localparam int Q      = 3329;
    localparam int TW_W   = LOG_N;
    localparam int CNT_W  = LOG_N - 1;
    localparam int LAY_W  = 3;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    typedef enum logic {NTT_FWD = 1'b0, NTT_INV = 1'b1} mode_t;

    // log2 of the butterfly span for a given issue-order layer
    function automatic logic [2:0] len_log2(input logic [LAY_W-1:0] lay, input mode_t m);
        return (m == NTT_FWD) ? 3'd7 - lay : lay + 3'd1;
    endfunction
endpackage

// File: rtl/ntt_bf_index_map.sv
// Combinational map from (butterfly index, span log2, mode) to coefficient and twiddle indices.
module ntt_bf_index_map
    import ntt_pkg::*;
(
    input  logic [CNT_W-1:0] c,
    input  logic [2:0]       l,
    input  mode_t            mode,
    output logic [LOG_N-1:0] addr_a,
    output logic [LOG_N-1:0] addr_b,
    output logic [TW_W-1:0]  tw_idx
);
    logic [LOG_N-1:0] cw, g, j, half;
    logic [3:0]       l1;

    always_comb begin
        l1     = {1'b0, l} + 4'd1;
        cw     = {1'b0, c};
        half   = LOG_N'(1) << l;
        g      = cw >> l;
        j      = cw & (half - LOG_N'(1));
        addr_a = (g << l1) | j;
        addr_b = addr_a + half;
        // group g selects the twiddle; forward counts up per layer, inverse counts down
        if (mode == NTT_FWD)
            tw_idx = (TW_W'(1) << (3'd7 - l)) + g;
        else
            tw_idx = (TW_W'(1) << (4'd8 - {1'b0, l})) - TW_W'(1) - g;
    end
endmodule

// File: rtl/ntt_twiddle_addr_gen.sv
// Walks all ML-KEM NTT / inverse NTT butterflies, one per handshake, with registered outputs.
module ntt_twiddle_addr_gen
    import ntt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inv,
    input  logic             bf_ready,
    output logic             bf_valid,
    output logic [LOG_N-1:0] addr_a,
    output logic [LOG_N-1:0] addr_b,
    output logic [TW_W-1:0]  tw_idx,
    output logic [LAY_W-1:0] layer,
    output logic             last,
    output logic             busy,
    output logic             done
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N/2 - 1);
    localparam logic [LAY_W-1:0] LAY_MAX = LAY_W'(NLAYER - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LAY_W-1:0] lay_q, lay_d;
    mode_t            mode_q, mode_d;
    logic             hs, load, fin_hs, last_d;
    logic [LOG_N-1:0] a_d, b_d;
    logic [TW_W-1:0]  tw_d;

    assign hs    = bf_valid && bf_ready;
    assign layer = lay_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state plus the counters of the butterfly to present next
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lay_d   = lay_q;
        mode_d  = mode_q;
        load    = 1'b0;
        fin_hs  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                cnt_d   = '0;
                lay_d   = '0;
                mode_d  = mode_t'(inv);
                load    = 1'b1;
            end
            RUN: if (hs) begin
                if (last) begin
                    state_d = FIN;
                    cnt_d   = '0;
                    lay_d   = '0;
                    fin_hs  = 1'b1;
                end else begin
                    load = 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        lay_d = lay_q + LAY_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        last_d = (lay_d == LAY_MAX) && (cnt_d == CNT_MAX);
    end

    ntt_bf_index_map u_map (
        .c      (cnt_d),
        .l      (len_log2(lay_d, mode_d)),
        .mode   (mode_d),
        .addr_a (a_d),
        .addr_b (b_d),
        .tw_idx (tw_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            lay_q    <= '0;
            mode_q   <= NTT_FWD;
            bf_valid <= 1'b0;
            addr_a   <= '0;
            addr_b   <= '0;
            tw_idx   <= '0;
            last     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lay_q  <= lay_d;
            mode_q <= mode_d;
            done   <= 1'b0;
            if (load) begin
                bf_valid <= 1'b1;
                busy     <= 1'b1;
                addr_a   <= a_d;
                addr_b   <= b_d;
                tw_idx   <= tw_d;
                last     <= last_d;
            end else if (fin_hs) begin
                bf_valid <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                addr_a   <= '0;
                addr_b   <= '0;
                tw_idx   <= '0;
                last     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ntt_twiddle_addr_gen.sv
// Scoreboard bench: expected butterflies come from the textbook ML-KEM NTT loop nests.
module tb_ntt_twiddle_addr_gen;
    logic       clk, rst, start, inv, bf_ready;
    logic       bf_valid, last, busy, done;
    logic [7:0] addr_a, addr_b, tw_idx;
    logic [2:0] layer;

    ntt_twiddle_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .inv(inv), .bf_ready(bf_ready),
        .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx),
        .layer(layer), .last(last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int a; int b; int tw; int lay; bit last; } exp_t;
    exp_t q[$];
    exp_t e;
    int   tests = 0, fails = 0;
    int   hs_tot = 0, done_tot = 0;
    bit   chk_fin = 0, hold = 0;
    logic [7:0] ha, hb, ht;
    logic [2:0] hl;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_model(input bit iv);
        int k, lay;
        lay = 0;
        if (!iv) begin
            k = 1;
            for (int len = 128; len >= 2; len = len / 2) begin
                for (int st = 0; st < 256; st += 2 * len) begin
                    for (int j = st; j < st + len; j++)
                        q.push_back('{a: j, b: j + len, tw: k, lay: lay, last: 1'b0});
                    k++;
                end
                lay++;
            end
        end else begin
            k = 127;
            for (int len = 2; len <= 128; len = len * 2) begin
                for (int st = 0; st < 256; st += 2 * len) begin
                    for (int j = st; j < st + len; j++)
                        q.push_back('{a: j, b: j + len, tw: k, lay: lay, last: 1'b0});
                    k--;
                end
                lay++;
            end
        end
        q[q.size()-1].last = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold    = 0;
            chk_fin = 0;
        end else begin
            if (chk_fin) begin
                chk("done_after_last", done, 1);
                chk("valid_after_last", bf_valid, 0);
                chk("busy_after_last", busy, 0);
                chk_fin = 0;
            end
            if (done) done_tot++;
            if (hold && bf_valid) begin
                chk("hold_a", addr_a, ha);
                chk("hold_b", addr_b, hb);
                chk("hold_tw", tw_idx, ht);
                chk("hold_layer", layer, hl);
            end
            hold = bf_valid && !bf_ready;
            ha = addr_a; hb = addr_b; ht = tw_idx; hl = layer;
            if (bf_valid && bf_ready) begin
                hs_tot++;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: unexpected butterfly a=%0d b=%0d tw=%0d", addr_a, addr_b, tw_idx);
                end else begin
                    e = q.pop_front();
                    chk("sb_a", addr_a, e.a);
                    chk("sb_b", addr_b, e.b);
                    chk("sb_tw", tw_idx, e.tw);
                    chk("sb_layer", layer, e.lay);
                    chk("sb_last", last, int'(e.last));
                end
                if (last) chk_fin = 1;
            end
        end
    end

    // mode: 0 ready always, 1 five-cycle stall at butterfly 40, 2 random 50%, 3 random plus stray starts
    task automatic run_xform(input bit iv, input int mode, input string tag);
        int hs0, dn0, bp;
        bit seen;
        q.delete();
        push_model(iv);
        hs0 = hs_tot; dn0 = done_tot; bp = 0; seen = 0;
        start = 1; inv = iv; bf_ready = 1;
        @(posedge clk); #1;
        start = 0; inv = ~iv;
        chk({tag, "_lat_valid"}, bf_valid, 1);
        chk({tag, "_lat_busy"}, busy, 1);
        for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
            case (mode)
                0: bf_ready = 1;
                1: if (hs_tot - hs0 == 40 && bp < 5) begin bf_ready = 0; bp++; end
                   else bf_ready = 1;
                2: bf_ready = 1'($urandom_range(1, 0));
                default: begin
                    bf_ready = ($urandom_range(3, 0) != 0);
                    start    = (cyc == 100 || cyc == 400);
                end
            endcase
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s_timeout: no done after %0d handshakes, required 896", tag, hs_tot - hs0);
        end
        start = (mode == 3);
        bf_ready = 0;
        @(posedge clk); #1;
        start = 0;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_valid"}, bf_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_handshakes"}, hs_tot - hs0, 896);
        chk({tag, "_done_count"}, done_tot - dn0, 1);
        chk({tag, "_sb_left"}, q.size(), 0);
    endtask

    task automatic reset_test();
        int hs0, dn0;
        q.delete();
        push_model(0);
        hs0 = hs_tot;
        start = 1; inv = 0; bf_ready = 1;
        @(posedge clk); #1;
        start = 0;
        for (int cyc = 0; cyc < 2000 && hs_tot - hs0 < 300; cyc++) begin
            @(posedge clk); #1;
        end
        chk("rst_reach_300", hs_tot - hs0, 300);
        rst = 1; bf_ready = 0;
        @(posedge clk); #1;
        chk("rst_mid_valid", bf_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_a", addr_a, 0);
        chk("rst_mid_b", addr_b, 0);
        chk("rst_mid_tw", tw_idx, 0);
        chk("rst_mid_layer", layer, 0);
        chk("rst_mid_last", last, 0);
        dn0 = done_tot;
        rst = 0;
        q.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_done", done_tot - dn0, 0);
        chk("rst_idle_valid", bf_valid, 0);
    endtask

    initial begin
        rst = 1; start = 0; inv = 0; bf_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", bf_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_last", last, 0);
        chk("reset_a", addr_a, 0);
        chk("reset_b", addr_b, 0);
        chk("reset_tw", tw_idx, 0);
        chk("reset_layer", layer, 0);
        rst = 0;
        @(posedge clk); #1;
        chk("idle_quiet", bf_valid, 0);
        run_xform(0, 0, "fwd");
        run_xform(1, 0, "inv");
        run_xform(0, 1, "bp");
        run_xform(0, 2, "rnd_fwd");
        run_xform(1, 2, "rnd_inv");
        reset_test();
        run_xform(0, 0, "restart");
        run_xform(1, 3, "stray");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
